// File: rtl/matmul_operand_fetch.sv
// Operand-fetch stage for the matmul datapath: reads A/B headers and elements from the SRAMs
// and streams {A[i][k], B[k][j]} pairs in row-major result order through a 2-entry buffer.
module matmul_operand_fetch #(
   parameter int unsigned ADDR_WIDTH = 12,
   parameter int unsigned DATA_WIDTH = 32,
   parameter int unsigned DIM_WIDTH  = 16
) (
   input  logic                  clk,
   input  logic                  reset_n,
   input  logic                  fetch_valid,
   output logic                  fetch_ready,
   output logic [ADDR_WIDTH-1:0] input_read_address,
   input  logic [DATA_WIDTH-1:0] input_read_data,
   output logic [ADDR_WIDTH-1:0] weight_read_address,
   input  logic [DATA_WIDTH-1:0] weight_read_data,
   output logic                  op_valid,
   input  logic                  op_ready,
   output logic [DATA_WIDTH-1:0] op_a,
   output logic [DATA_WIDTH-1:0] op_b,
   output logic                  op_last,
   output logic                  op_first,
   output logic [DIM_WIDTH-1:0]  res_rows,
   output logic [DIM_WIDTH-1:0]  res_cols,
   output logic                  dim_err
);

   typedef enum logic [2:0] {StIdle, StHdr, StHdrWait, StStream, StDrain, StDone} state_t;

   typedef struct packed {
      logic [DATA_WIDTH-1:0] a;
      logic [DATA_WIDTH-1:0] b;
      logic                  first;
      logic                  last;
   } pair_t;

   state_t state_q, state_d;

   logic [DIM_WIDTH-1:0]  m_q, k_q, n_q, i_q, j_q, kc_q;
   logic [ADDR_WIDTH-1:0] a_ptr_q, a_base_q, b_ptr_q, b_col_q, a_last_q, b_last_q;
   logic                  dim_err_q;
   logic                  infl_q, infl_first_q, infl_last_q;
   pair_t [1:0]           mem_q;
   logic                  wr_q, rd_q;
   logic [1:0]            cnt_q;

   logic [DIM_WIDTH-1:0]  hdr_a_rows, hdr_a_cols, hdr_b_rows, hdr_b_cols;
   logic [ADDR_WIDTH-1:0] k_ext, n_ext;
   logic                  hdr_bad, hdr_zero;
   logic                  k_end, j_end, i_end, issue, pop, fifo_pop, push, start;
   pair_t                 arr, head;

   assign hdr_a_rows = input_read_data[2*DIM_WIDTH-1:DIM_WIDTH];
   assign hdr_a_cols = input_read_data[DIM_WIDTH-1:0];
   assign hdr_b_rows = weight_read_data[2*DIM_WIDTH-1:DIM_WIDTH];
   assign hdr_b_cols = weight_read_data[DIM_WIDTH-1:0];
   assign hdr_bad    = hdr_a_cols != hdr_b_rows;
   assign hdr_zero   = (hdr_a_rows == '0) || (hdr_a_cols == '0) || (hdr_b_cols == '0);

   assign k_ext = ADDR_WIDTH'(k_q);
   assign n_ext = ADDR_WIDTH'(n_q);
   assign k_end = kc_q == k_q - 1'b1;
   assign j_end = j_q == n_q - 1'b1;
   assign i_end = i_q == m_q - 1'b1;

   // The arriving SRAM word bypasses the buffer when it is empty, hiding the read latency.
   assign arr      = '{a: input_read_data, b: weight_read_data,
                       first: infl_first_q, last: infl_last_q};
   assign head     = (cnt_q != 2'd0) ? mem_q[rd_q] : arr;
   assign op_valid = (cnt_q != 2'd0) || infl_q;
   assign pop      = op_valid && op_ready;
   assign fifo_pop = pop && (cnt_q != 2'd0);
   assign push     = infl_q && !((cnt_q == 2'd0) && pop);
   assign issue    = (state_q == StStream) &&
                     (({1'b0, cnt_q} + {2'b0, infl_q} - {2'b0, pop}) < 3'd2);
   assign start    = (state_q == StIdle) && fetch_valid;

   assign op_a     = op_valid ? head.a : '0;
   assign op_b     = op_valid ? head.b : '0;
   assign op_first = op_valid && head.first;
   assign op_last  = op_valid && head.last;

   assign fetch_ready = state_q == StIdle;
   assign res_rows    = m_q;
   assign res_cols    = n_q;
   assign dim_err     = dim_err_q;

   always_comb begin
      input_read_address  = a_last_q;
      weight_read_address = b_last_q;
      if (state_q == StHdr) begin
         input_read_address  = '0;
         weight_read_address = '0;
      end else if (issue) begin
         input_read_address  = a_ptr_q;
         weight_read_address = b_ptr_q;
      end
   end

   always_comb begin
      state_d = state_q;
      unique case (state_q)
         StIdle:    if (fetch_valid) state_d = StHdr;
         StHdr:     state_d = StHdrWait;
         StHdrWait: state_d = (hdr_bad || hdr_zero) ? StDone : StStream;
         StStream:  if (issue && k_end && j_end && i_end) state_d = StDrain;
         StDrain:   if ((cnt_q == 2'd0) && !infl_q) state_d = StDone;
         StDone:    state_d = StIdle;
         default:   state_d = StIdle;
      endcase
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) state_q <= StIdle;
      else          state_q <= state_d;
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         m_q <= '0; k_q <= '0; n_q <= '0; i_q <= '0; j_q <= '0; kc_q <= '0;
         a_ptr_q <= '0; a_base_q <= '0; b_ptr_q <= '0; b_col_q <= '0;
         a_last_q <= '0; b_last_q <= '0;
         dim_err_q <= 1'b0;
      end else begin
         if (start) dim_err_q <= 1'b0;
         if (state_q == StHdr) begin
            a_last_q <= '0;
            b_last_q <= '0;
         end
         if (state_q == StHdrWait) begin
            m_q       <= hdr_a_rows;
            k_q       <= hdr_a_cols;
            n_q       <= hdr_b_cols;
            dim_err_q <= hdr_bad;
            i_q <= '0; j_q <= '0; kc_q <= '0;
            a_ptr_q <= ADDR_WIDTH'(1); a_base_q <= ADDR_WIDTH'(1);
            b_ptr_q <= ADDR_WIDTH'(1); b_col_q  <= ADDR_WIDTH'(1);
         end
         if (issue) begin
            a_last_q <= a_ptr_q;
            b_last_q <= b_ptr_q;
            if (!k_end) begin
               kc_q    <= kc_q + 1'b1;
               a_ptr_q <= a_ptr_q + 1'b1;
               b_ptr_q <= b_ptr_q + n_ext;
            end else if (!j_end) begin
               kc_q    <= '0;
               j_q     <= j_q + 1'b1;
               a_ptr_q <= a_base_q;
               b_ptr_q <= b_col_q + 1'b1;
               b_col_q <= b_col_q + 1'b1;
            end else begin
               kc_q     <= '0;
               j_q      <= '0;
               i_q      <= i_q + 1'b1;
               a_base_q <= a_base_q + k_ext;
               a_ptr_q  <= a_base_q + k_ext;
               b_ptr_q  <= ADDR_WIDTH'(1);
               b_col_q  <= ADDR_WIDTH'(1);
            end
         end
      end
   end

   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         infl_q <= 1'b0; infl_first_q <= 1'b0; infl_last_q <= 1'b0;
         mem_q <= '0; wr_q <= 1'b0; rd_q <= 1'b0; cnt_q <= 2'd0;
      end else begin
         infl_q       <= issue;
         infl_first_q <= issue && (kc_q == '0);
         infl_last_q  <= issue && k_end;
         if (push) begin
            mem_q[wr_q] <= arr;
            wr_q        <= ~wr_q;
         end
         if (fifo_pop) rd_q <= ~rd_q;
         cnt_q <= cnt_q + 2'(push) - 2'(fifo_pop);
      end
   end

endmodule

// File: tb/tb_matmul_operand_fetch.sv
// Directed bench for matmul_operand_fetch: job table with SRAM models and an order checker,
// plus a mid-job reset sequence.
module tb_matmul_operand_fetch;

   localparam int AW = 12;
   localparam int DW = 32;
   localparam int DMW = 16;

   logic          clk = 1'b0;
   logic          reset_n = 1'b0;
   logic          fetch_valid = 1'b0;
   logic          fetch_ready;
   logic [AW-1:0] input_read_address, weight_read_address;
   logic [DW-1:0] input_read_data = '0, weight_read_data = '0;
   logic          op_valid, op_ready = 1'b0, op_last, op_first, dim_err;
   logic [DW-1:0] op_a, op_b;
   logic [DMW-1:0] res_rows, res_cols;

   logic [DW-1:0] in_mem [0:4095];
   logic [DW-1:0] w_mem  [0:4095];

   int n_tests = 0;
   int n_fail  = 0;

   matmul_operand_fetch #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .DIM_WIDTH(DMW)) dut (
      .clk                 (clk),
      .reset_n             (reset_n),
      .fetch_valid         (fetch_valid),
      .fetch_ready         (fetch_ready),
      .input_read_address  (input_read_address),
      .input_read_data     (input_read_data),
      .weight_read_address (weight_read_address),
      .weight_read_data    (weight_read_data),
      .op_valid            (op_valid),
      .op_ready            (op_ready),
      .op_a                (op_a),
      .op_b                (op_b),
      .op_last             (op_last),
      .op_first            (op_first),
      .res_rows            (res_rows),
      .res_cols            (res_cols),
      .dim_err             (dim_err)
   );

   always #5 clk = ~clk;

   always_ff @(posedge clk) begin
      input_read_data  <= in_mem[input_read_address];
      weight_read_data <= w_mem[weight_read_address];
   end

   typedef struct {
      int m; int k; int kb; int n;
      bit rnd; int abort;
      int exp_pairs; bit exp_err;
   } job_t;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end
   endtask

   function automatic logic [31:0] aval(input int id, input int i, input int k);
      return 32'hA000_0000 | 32'(id << 16) | 32'(i << 8) | 32'(k);
   endfunction

   function automatic logic [31:0] bval(input int id, input int k, input int j);
      return 32'hB000_0000 | 32'(id << 16) | 32'(k << 8) | 32'(j);
   endfunction

   task automatic run_job(input job_t jb, input int id);
      int t, idx, got, first_idx, last_acc, fr_idx, ei, ej, ek;
      bit prev_stall, timed_out;
      logic [DW-1:0] pa, pb;
      logic pf, pl;
      in_mem[0] = {16'(jb.m), 16'(jb.k)};
      w_mem[0]  = {16'(jb.kb), 16'(jb.n)};
      for (int i = 0; i < jb.m; i++)
         for (int k = 0; k < jb.k; k++) in_mem[1 + i * jb.k + k] = aval(id, i, k);
      for (int k = 0; k < jb.kb; k++)
         for (int j = 0; j < jb.n; j++) w_mem[1 + k * jb.n + j] = bval(id, k, j);
      t = 0;
      while (!fetch_ready && t < 100) begin
         @(negedge clk);
         t++;
      end
      chk("ready_before_start", {31'b0, fetch_ready}, 32'd1);
      fetch_valid = 1'b1;
      @(posedge clk);
      #1;
      fetch_valid = 1'b0;
      op_ready = jb.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
      @(negedge clk);
      idx = 0; got = 0; first_idx = -1; last_acc = -1; fr_idx = -1;
      ei = 0; ej = 0; ek = 0; prev_stall = 1'b0; timed_out = 1'b1;
      pa = '0; pb = '0; pf = 1'b0; pl = 1'b0;
      while (idx < 3000) begin
         if (fetch_ready) begin
            fr_idx = idx;
            timed_out = 1'b0;
            break;
         end
         if (op_valid) begin
            if (first_idx < 0) first_idx = idx;
            if (prev_stall)
               chk("stall_hold", {op_a ^ pa} | {op_b ^ pb} | 32'({op_first ^ pf, op_last ^ pl}),
                   32'd0);
            if (op_ready) begin
               if (got < jb.exp_pairs) begin
                  chk("op_a", op_a, aval(id, ei, ek));
                  chk("op_b", op_b, bval(id, ek, ej));
                  chk("op_first_last", {30'b0, op_first, op_last},
                      {30'b0, ek == 0, ek == jb.k - 1});
               end else begin
                  chk("extra_pair", 32'(got), 32'(jb.exp_pairs - 1));
               end
               got++;
               last_acc = idx;
               if (ek == jb.k - 1) begin
                  ek = 0;
                  if (ej == jb.n - 1) begin ej = 0; ei++; end
                  else ej++;
               end else ek++;
               if (got == jb.abort) begin
                  @(posedge clk);
                  #1;
                  reset_n = 1'b0;
                  #1;
                  chk("rst_op_valid", {31'b0, op_valid}, 32'd0);
                  chk("rst_fetch_ready", {31'b0, fetch_ready}, 32'd1);
                  chk("rst_outputs", op_a | op_b | 32'(input_read_address) |
                      32'(weight_read_address) | 32'({op_first, op_last, dim_err}), 32'd0);
                  chk("rst_dims", {res_rows, res_cols}, 32'd0);
                  @(negedge clk);
                  chk("rst_hold_valid", {31'b0, op_valid}, 32'd0);
                  reset_n = 1'b1;
                  return;
               end
            end
            prev_stall = !op_ready;
            pa = op_a; pb = op_b; pf = op_first; pl = op_last;
         end else begin
            if (prev_stall) chk("stall_valid_kept", 32'd0, 32'd1);
            prev_stall = 1'b0;
         end
         @(posedge clk);
         #1;
         op_ready = jb.rnd ? 1'($urandom_range(0, 1)) : 1'b1;
         @(negedge clk);
         idx++;
      end
      chk("job_timeout", {31'b0, timed_out}, 32'd0);
      chk("pair_count", 32'(got), 32'(jb.exp_pairs));
      chk("dim_err", {31'b0, dim_err}, {31'b0, jb.exp_err});
      chk("res_rows", 32'(res_rows), 32'(jb.m));
      chk("res_cols", 32'(res_cols), 32'(jb.n));
      if (jb.exp_pairs > 0) begin
         chk("first_latency", 32'(first_idx), 32'd3);
         chk("ready_return", 32'(fr_idx - last_acc), 32'd3);
         if (!jb.rnd) chk("no_bubbles", 32'(last_acc - first_idx + 1), 32'(jb.exp_pairs));
      end else begin
         chk("no_op_valid", 32'(first_idx), 32'hFFFF_FFFF);
         chk("ready_within_4", {31'b0, fr_idx <= 4}, 32'd1);
      end
   endtask

   initial begin
      job_t jobs[9];
      jobs[0] = '{m: 2, k: 3, kb: 3, n: 2, rnd: 1'b0, abort: -1, exp_pairs: 12, exp_err: 1'b0};
      jobs[1] = '{m: 2, k: 3, kb: 3, n: 2, rnd: 1'b1, abort: -1, exp_pairs: 12, exp_err: 1'b0};
      jobs[2] = '{m: 2, k: 3, kb: 4, n: 2, rnd: 1'b0, abort: -1, exp_pairs: 0,  exp_err: 1'b1};
      jobs[3] = '{m: 1, k: 1, kb: 1, n: 1, rnd: 1'b0, abort: -1, exp_pairs: 1,  exp_err: 1'b0};
      jobs[4] = '{m: 0, k: 3, kb: 3, n: 2, rnd: 1'b0, abort: -1, exp_pairs: 0,  exp_err: 1'b0};
      jobs[5] = '{m: 3, k: 2, kb: 2, n: 0, rnd: 1'b0, abort: -1, exp_pairs: 0,  exp_err: 1'b0};
      jobs[6] = '{m: 4, k: 4, kb: 4, n: 4, rnd: 1'b0, abort: 5,  exp_pairs: 64, exp_err: 1'b0};
      jobs[7] = '{m: 4, k: 4, kb: 4, n: 4, rnd: 1'b0, abort: -1, exp_pairs: 64, exp_err: 1'b0};
      jobs[8] = '{m: 3, k: 2, kb: 2, n: 4, rnd: 1'b1, abort: -1, exp_pairs: 24, exp_err: 1'b0};
      for (int a = 0; a < 4096; a++) begin
         in_mem[a] = '0;
         w_mem[a]  = '0;
      end
      #1;
      chk("reset_fetch_ready", {31'b0, fetch_ready}, 32'd1);
      chk("reset_outputs", op_a | op_b | 32'(input_read_address) | 32'(weight_read_address) |
          32'({op_valid, op_first, op_last, dim_err}) | {res_rows, res_cols}, 32'd0);
      @(negedge clk);
      @(negedge clk);
      reset_n = 1'b1;
      @(negedge clk);
      // Jobs run back-to-back: each start lands on the cycle the previous fetch_ready rises.
      for (int n = 0; n < 9; n++) run_job(jobs[n], n);
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
